// File: rtl/mmu_pkg.sv
// mmu_pkg: mmu bus transfer codes, burst length/address helpers and burst initiator FSM states
package mmu_pkg;
    localparam int MMU_ADDR_W = 32;
    localparam logic [2:0] TRANSFER_IDLE   = 3'd0;
    localparam logic [2:0] TRANSFER_BUSY   = 3'd1;
    localparam logic [2:0] TRANSFER_NONSEQ = 3'd2;
    localparam logic [2:0] TRANSFER_SEQ    = 3'd3;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ERR, S_DONE} init_state_t;

    function automatic logic [4:0] burst_beats(input logic [2:0] burst);
        return burst[2:1] == 2'b00 ? 5'd1 : burst[2:1] == 2'b01 ? 5'd4 : burst[2:1] == 2'b10 ? 5'd8 : 5'd16;
    endfunction

    // wrapping bursts keep the upper address bits and roll the low bits inside the burst window
    function automatic logic [MMU_ADDR_W-1:0] next_burst_addr(input logic [MMU_ADDR_W-1:0] addr,
                                                              input logic [2:0] size,
                                                              input logic [2:0] burst);
        logic [MMU_ADDR_W-1:0] inc;
        logic [MMU_ADDR_W-1:0] mask;
        inc  = MMU_ADDR_W'(1) << size;
        mask = inc * MMU_ADDR_W'(burst_beats(burst)) - MMU_ADDR_W'(1);
        return burst[0] ? (addr & ~mask) | ((addr + inc) & mask) : addr + inc;
    endfunction
endpackage

// File: rtl/mmu_burst_initiator_if.sv
// mmu_burst_initiator_if: client request/data channels plus mmu bus signals of the burst initiator
interface mmu_burst_initiator_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_write;
    logic [2:0]        req_size;
    logic [2:0]        req_burst;
    logic              wdata_valid;
    logic [DATA_W-1:0] wdata;
    logic              wdata_ready;
    logic              rdata_valid;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              err;
    logic              SELX;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] WRITE_DATA;
    logic [DATA_W-1:0] READ_DATA;
    logic              WRITE;
    logic [2:0]        SIZE;
    logic [2:0]        BURST;
    logic [2:0]        TRANS;
    logic              READYOUT;
    logic              RESP;

    modport master (
        input  req_valid, req_addr, req_write, req_size, req_burst, wdata_valid, wdata,
               READ_DATA, READYOUT, RESP,
        output req_ready, wdata_ready, rdata_valid, rdata, done, err,
               SELX, ADDR, WRITE_DATA, WRITE, SIZE, BURST, TRANS
    );

    modport slave (
        output req_valid, req_addr, req_write, req_size, req_burst, wdata_valid, wdata,
               READ_DATA, READYOUT, RESP,
        input  req_ready, wdata_ready, rdata_valid, rdata, done, err,
               SELX, ADDR, WRITE_DATA, WRITE, SIZE, BURST, TRANS
    );
endinterface

// File: rtl/mmu_burst_addr_gen.sv
// mmu_burst_addr_gen: registered beat address, beat counter and first/last beat flags
module mmu_burst_addr_gen import mmu_pkg::*; #(parameter int ADDR_W = 32) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              adv,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [2:0]        size,
    input  logic [2:0]        burst,
    output logic [ADDR_W-1:0] addr,
    output logic              first,
    output logic              last
);
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        cnt_q, cnt_d;

    // load the start address on accept, step to the following beat address on each completed beat
    always_comb begin
        addr_d = load ? start_addr : adv ? next_burst_addr(addr_q, size, burst) : addr_q;
        cnt_d  = load ? 5'd0 : adv ? cnt_q + 5'd1 : cnt_q;
    end

    // beat address and beat count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr  = addr_q;
    assign first = cnt_q == 5'd0;
    assign last  = cnt_q == burst_beats(burst) - 5'd1;
endmodule

// File: rtl/mmu_burst_initiator.sv
// mmu_burst_initiator: single-burst mmu bus initiator (INCR/WRAP, error abort); MMU_INIT_BUSY_EN adds BUSY on write-data stalls
module mmu_burst_initiator import mmu_pkg::*; #(parameter int ADDR_W = 32, parameter int DATA_W = 32) (
    input logic                 CLK,
    input logic                 RSTN,
    mmu_burst_initiator_if.master bus
);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

    init_state_t       state_q, state_d;
    logic              selx_q, selx_d, write_q, write_d, rdata_valid_q, rdata_valid_d, err_q, err_d;
    logic [2:0]        trans_q, trans_d, size_q, size_d, burst_q, burst_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr;
    logic              req_bad, issue, load, adv, first, last;

    assign req_bad = bus.req_size > MAX_SIZE ||
                     (bus.req_addr & ((ADDR_W'(1) << bus.req_size) - ADDR_W'(1))) != '0;
    assign issue   = state_q == S_ISSUE && (!write_q || bus.wdata_valid);
    assign load    = state_q == S_IDLE && bus.req_valid && !req_bad;
    assign adv     = state_q == S_WAIT && bus.READYOUT && !bus.RESP && !last;

    mmu_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk(CLK), .rst(RSTN), .load(load), .adv(adv), .start_addr(bus.req_addr),
        .size(size_q), .burst(burst_q), .addr(addr), .first(first), .last(last)
    );

    // burst sequencing: accept, issue beat, wait for response, error drain, done pulse
    always_comb begin
        state_d       = state_q;
        selx_d        = selx_q;
        trans_d       = trans_q;
        write_d       = write_q;
        size_d        = size_q;
        burst_d       = burst_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        err_d         = err_q;
        case (state_q)
            S_IDLE: if (bus.req_valid) begin
                state_d = req_bad ? S_DONE : S_ISSUE;
                err_d   = req_bad;
                if (!req_bad) begin
                    selx_d  = 1'b1;
                    write_d = bus.req_write;
                    size_d  = bus.req_size;
                    burst_d = bus.req_burst;
                end
            end
            S_ISSUE: if (issue) begin
                state_d = S_WAIT;
                trans_d = first ? TRANSFER_NONSEQ : TRANSFER_SEQ;
                wdata_d = write_q ? bus.wdata : wdata_q;
            end else begin
`ifdef MMU_INIT_BUSY_EN
                trans_d = first ? TRANSFER_IDLE : TRANSFER_BUSY;
`else
                trans_d = TRANSFER_IDLE;
`endif
            end
            S_WAIT: if (bus.READYOUT && !bus.RESP) begin
                state_d       = last ? S_DONE : S_ISSUE;
                selx_d        = !last;
                trans_d       = TRANSFER_IDLE;
                rdata_valid_d = !write_q;
                rdata_d       = write_q ? rdata_q : bus.READ_DATA;
            end else if (!bus.READYOUT && bus.RESP) begin
                state_d = S_ERR;
                trans_d = TRANSFER_IDLE;
            end
            S_ERR: if (bus.READYOUT && bus.RESP) begin
                state_d = S_DONE;
                selx_d  = 1'b0;
                err_d   = 1'b1;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // state and bus output registers; reset drops any burst in flight without a done pulse
    always_ff @(posedge CLK or posedge RSTN) begin
        if (RSTN) begin
            state_q       <= S_IDLE;
            selx_q        <= 1'b0;
            trans_q       <= TRANSFER_IDLE;
            write_q       <= 1'b0;
            size_q        <= '0;
            burst_q       <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            selx_q        <= selx_d;
            trans_q       <= trans_d;
            write_q       <= write_d;
            size_q        <= size_d;
            burst_q       <= burst_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            err_q         <= err_d;
        end
    end

    assign bus.req_ready   = state_q == S_IDLE;
    assign bus.wdata_ready = issue && write_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.rdata       = rdata_q;
    assign bus.done        = state_q == S_DONE;
    assign bus.err         = state_q == S_DONE && err_q;
    assign bus.SELX        = selx_q;
    assign bus.ADDR        = addr;
    assign bus.WRITE_DATA  = wdata_q;
    assign bus.WRITE       = write_q;
    assign bus.SIZE        = size_q;
    assign bus.BURST       = burst_q;
    assign bus.TRANS       = trans_q;
endmodule

// File: tb/tb_mmu_burst_initiator.sv
// tb_mmu_burst_initiator: scoreboard bench with a scripted mmu responder and write-data feeder
module tb_mmu_burst_initiator;
    import mmu_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  trans;
        logic [31:0] data;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmu_burst_initiator_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mmu_burst_initiator #(.ADDR_W(32), .DATA_W(32)) dut (.CLK(clk), .RSTN(rst), .bus(bus));

    int total = 0;
    int bad = 0;
    beat_t       beat_q[$];
    logic [31:0] rd_q[$];
    logic        exp_err_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] mem[256];
    int n_wait = 0, err_beat = -1, r_beat = 0, r_wc = 0;
    int gap_idx = -1, gap_cnt = 0, wi = 0, busy_cnt = 0, done_cnt = 0, d_base = 0;
    bit r_errph = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] a, input int sz, input int nb,
                                             input bit wrap, input int i);
        logic [31:0] inc, tot, base;
        inc  = 32'(1 << sz);
        tot  = inc * 32'(nb);
        base = a - a % tot;
        return wrap ? base + (a - base + inc * 32'(i)) % tot : a + inc * 32'(i);
    endfunction

    // responder: n_wait wait cycles per beat, two-cycle error on beat err_beat
    initial begin
        bus.READYOUT  = 1'b0;
        bus.RESP      = 1'b0;
        bus.READ_DATA = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.READ_DATA = mem[bus.ADDR[9:2]];
            {bus.READYOUT, bus.RESP} = 2'b00;
            if (rst) begin
                r_errph = 1'b0;
                r_wc    = 0;
            end else if (r_errph) begin
                {bus.READYOUT, bus.RESP} = 2'b11;
                r_errph = 1'b0;
            end else if (bus.TRANS == TRANSFER_NONSEQ || bus.TRANS == TRANSFER_SEQ) begin
                if (r_beat == err_beat) begin
                    {bus.READYOUT, bus.RESP} = 2'b01;
                    r_errph = 1'b1;
                    r_beat  = -100;
                end else if (r_wc < n_wait) begin
                    r_wc++;
                end else begin
                    {bus.READYOUT, bus.RESP} = 2'b10;
                    r_wc = 0;
                    r_beat++;
                end
            end
        end
    end

    // write-data feeder: holds wdata_valid low for gap_cnt issue cycles before data word gap_idx
    initial begin
        bit consumed;
        bit hold;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        forever begin
            @(negedge clk);
            consumed = bus.wdata_valid && bus.wdata_ready;
            @(posedge clk);
            #1;
            if (consumed) begin
                void'(wd_q.pop_front());
                wi++;
            end
            hold = wi == gap_idx && gap_cnt > 0 && bus.SELX && !bus.req_ready &&
                   bus.TRANS != TRANSFER_NONSEQ && bus.TRANS != TRANSFER_SEQ;
            if (hold) gap_cnt--;
            bus.wdata_valid = wd_q.size() > 0 && !hold;
            bus.wdata       = wd_q.size() > 0 ? wd_q[0] : '0;
        end
    end

    // monitor: compares completed beats, read data and done/err against the scoreboard
    initial begin
        beat_t b;
        bit saw01;
        saw01 = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.TRANS == TRANSFER_BUSY) busy_cnt++;
            if (saw01) check("trans_after_err", bus.TRANS, TRANSFER_IDLE);
            saw01 = !rst && !bus.READYOUT && bus.RESP;
            if (!rst && bus.READYOUT && !bus.RESP &&
                (bus.TRANS == TRANSFER_NONSEQ || bus.TRANS == TRANSFER_SEQ)) begin
                if (beat_q.size() == 0) check("beat_expected", beat_q.size(), 1);
                else begin
                    b = beat_q.pop_front();
                    check("addr", bus.ADDR, b.addr);
                    check("trans", bus.TRANS, b.trans);
                    check("write", bus.WRITE, b.write);
                    check("size", bus.SIZE, b.size);
                    check("burst", bus.BURST, b.burst);
                    check("selx", bus.SELX, 1);
                    check("req_ready_busy", bus.req_ready, 0);
                    if (b.write) begin
                        check("wdata", bus.WRITE_DATA, b.data);
                        mem[bus.ADDR[9:2]] = bus.WRITE_DATA;
                    end
                end
            end
            if (bus.rdata_valid) begin
                if (rd_q.size() == 0) check("rdata_expected", rd_q.size(), 1);
                else check("rdata", bus.rdata, rd_q.pop_front());
            end
            if (bus.done) begin
                done_cnt++;
                if (exp_err_q.size() == 0) check("done_expected", exp_err_q.size(), 1);
                else check("err", bus.err, exp_err_q.pop_front());
            end
        end
    end

    task automatic start_burst(input logic [31:0] a, input bit wr, input logic [2:0] sz,
                               input logic [2:0] bu, input int nw, input int eb,
                               input int gi, input int gl);
        int nb, nbeat, ndat;
        bit bad_req, aborted;
        logic [31:0] ea, d;
        nb      = bu[2:1] == 2'd0 ? 1 : 2 << bu[2:1];
        bad_req = (a % (32'd1 << sz)) != 0 || sz > 3'd2;
        aborted = eb >= 0 && eb < nb;
        nbeat   = bad_req ? 0 : aborted ? eb : nb;
        ndat    = bad_req ? 0 : aborted ? eb + 1 : nb;
        n_wait = nw; err_beat = eb; r_beat = 0; r_wc = 0;
        gap_idx = gi; gap_cnt = gl; wi = 0;
        for (int i = 0; i < ndat; i++) begin
            ea = exp_addr(a, int'(sz), nb, bu[0], i);
            d  = $urandom;
            if (wr) wd_q.push_back(d);
            if (i < nbeat) begin
                beat_q.push_back('{addr: ea, trans: i == 0 ? TRANSFER_NONSEQ : TRANSFER_SEQ,
                                   data: d, write: wr, size: sz, burst: bu});
                if (!wr) rd_q.push_back(mem[ea[9:2]]);
            end
        end
        exp_err_q.push_back(bad_req || aborted);
        d_base = done_cnt;
        @(negedge clk);
        bus.req_addr  = a;
        bus.req_write = wr;
        bus.req_size  = sz;
        bus.req_burst = bu;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (bad_req) begin
            check("bad_done", bus.done, 1);
            check("bad_err", bus.err, 1);
            check("bad_selx", bus.SELX, 0);
        end
    endtask

    task automatic wait_done(input string tag);
        for (int c = 0; c < 400 && done_cnt == d_base; c++) @(negedge clk);
        check({tag, "_done"}, done_cnt - d_base, 1);
        check({tag, "_beats_left"}, beat_q.size(), 0);
        check({tag, "_rdata_left"}, rd_q.size(), 0);
        wd_q.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + i;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_write = 1'b0;
        bus.req_size  = '0;
        bus.req_burst = '0;
        @(negedge clk);
        check("rst_selx", bus.SELX, 0);
        check("rst_trans", bus.TRANS, TRANSFER_IDLE);
        check("rst_addr", bus.ADDR, 0);
        check("rst_wdata", bus.WRITE_DATA, 0);
        check("rst_size_burst_write", {bus.SIZE, bus.BURST, bus.WRITE}, 0);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_outs", {bus.wdata_ready, bus.rdata_valid, bus.done, bus.err}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        start_burst(32'h10, 1'b0, 3'd2, 3'b000, 0, -1, -1, 0);
        wait_done("single_rd");
        start_burst(32'h20, 1'b1, 3'd2, 3'b010, 0, -1, -1, 0);
        wait_done("incr4_wr");
        start_burst(32'h38, 1'b0, 3'd2, 3'b011, 1, -1, -1, 0);
        wait_done("wrap4_rd");
        start_burst(32'h80, 1'b0, 3'd2, 3'b100, 0, 2, -1, 0);
        wait_done("incr8_err");
        start_burst(32'h12, 1'b0, 3'd2, 3'b010, 0, -1, -1, 0);
        wait_done("misaligned");
        start_burst(32'h40, 1'b1, 3'd3, 3'b000, 0, -1, -1, 0);
        wait_done("oversize");
        start_burst(32'h1A, 1'b1, 3'd1, 3'b101, 2, -1, -1, 0);
        wait_done("wrap8_wr");
        busy_cnt = 0;
        start_burst(32'h60, 1'b1, 3'd2, 3'b010, 0, -1, 1, 3);
        wait_done("stall_wr");
`ifdef MMU_INIT_BUSY_EN
        check("busy_cycles", busy_cnt, 3);
`else
        check("busy_cycles", busy_cnt, 0);
`endif

        start_burst(32'h100, 1'b0, 3'd2, 3'b110, 1, -1, -1, 0);
        repeat (10) @(negedge clk);
        check("mid_selx", bus.SELX, 1);
        check("mid_req_ready", bus.req_ready, 0);
        rst = 1'b1;
        #1;
        check("arst_selx", bus.SELX, 0);
        check("arst_trans", bus.TRANS, TRANSFER_IDLE);
        check("arst_addr", bus.ADDR, 0);
        check("arst_size_burst", {bus.SIZE, bus.BURST}, 0);
        check("arst_req_ready", bus.req_ready, 1);
        check("arst_outs", {bus.done, bus.err, bus.rdata_valid}, 0);
        beat_q.delete();
        rd_q.delete();
        exp_err_q.delete();
        d_base = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("arst_no_done", done_cnt - d_base, 0);
        start_burst(32'h44, 1'b0, 3'd2, 3'b000, 1, -1, -1, 0);
        wait_done("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
